param_fetch_seq: RTL

- Consumer side of the per-step weight/bias address map.
- Takes a {firstaddr, lastaddr, re_weights, re_bias} window and sequences reads from the weight or bias memory.
- Streams the fetched words, with backpressure, to the convolution engine's coefficient loaders.
- Sits between the address map, the parameter RAMs and the conv datapath; one window per start pulse.

---
 rtl/param_fetch_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/param_fetch_seq.sv
// param_fetch_seq: streams the words of one [firstaddr,lastaddr) window from weight or bias RAM (FETCH_CHECKSUM_EN adds csum).
// Latency: first out_valid 2 cycles after an accepted start; 1 word/cycle while out_ready stays high.
// Backpressure: reads pause once FIFO entries plus reads in flight reach 2; a stalled word holds steady.

module pfs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module param_fetch_seq #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 19,
  parameter int CNT_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] firstaddr,
  input  logic [ADDR_W-1:0] lastaddr,
  input  logic              re_weights,
  input  logic              re_bias,
  output logic              w_re,
  output logic              b_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] w_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_bias,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef FETCH_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);
  localparam int FIFO_DEPTH = 2;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] dat;
  } word_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic              tgt_bias_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic              start_bad;
  logic              accept;
  logic              empty_win;
  logic [CNT_W-1:0]  win_len;
  logic [FCW-1:0]    fifo_cnt;
  logic [1:0]        slots_used;
  logic              fifo_empty;
  logic              issue;
  logic              issue_last;
  logic              push;
  logic              pop;
  logic              xfer;
  word_t             rd_word;
  word_t             fifo_head;
  word_t             out_word;

  assign start_bad  = (re_weights == re_bias) || (lastaddr < firstaddr);
  assign accept     = (state_q == IDLE) && start && !start_bad;
  assign empty_win  = (lastaddr == firstaddr);
  assign win_len    = CNT_W'(lastaddr) - CNT_W'(firstaddr);

  // Words in the FIFO plus the read whose data lands this cycle.
  assign fifo_empty = (fifo_cnt == '0);
  assign slots_used = fifo_cnt + {1'b0, inflight_q};
  assign issue      = (state_q == RUN) && (slots_used < 2'd2);
  assign issue_last = issue && (rem_q == CNT_W'(1));

  assign rd_word.last = inflight_last_q;
  assign rd_word.dat  = tgt_bias_q ? b_rdata : w_rdata;

  // Fresh read data bypasses an empty FIFO; it is only stored if not taken now.
  assign out_word  = fifo_empty ? rd_word : fifo_head;
  assign out_valid = inflight_q || !fifo_empty;
  assign xfer      = out_valid && out_ready;
  assign push      = inflight_q && !(fifo_empty && out_ready);
  assign pop       = !fifo_empty && out_ready;

  pfs_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (rd_word),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !start_bad) state_d = empty_win ? FIN : RUN;
      end
      RUN: begin
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (xfer && out_word.last) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      tgt_bias_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err             <= 1'b0;
    end else begin
      state_q         <= state_d;
      err             <= (state_q == IDLE) && start && start_bad;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      if (accept) begin
        addr_q     <= firstaddr;
        rem_q      <= win_len;
        tgt_bias_q <= re_bias;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  assign w_re        = issue && !tgt_bias_q;
  assign b_re        = issue && tgt_bias_q;
  assign mem_addr    = issue ? addr_q : '0;
  assign out_data    = out_valid ? out_word.dat : '0;
  assign out_last    = out_valid && out_word.last;
  assign out_is_bias = tgt_bias_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == FIN);

`ifdef FETCH_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum + 32'(out_data);
    end
  end
`endif
endmodule
